uart_tx_engine: RTL and testbench
=================================

# uart_tx_engine

Serial transmitter that consumes the one-cycle `baud_tick` enable produced by the baud rate generator and shifts out asynchronous UART frames: start bit, data LSB first, optional parity, and 1 or 2 stop bits. A one-entry holding register with a valid/ready handshake sits in front of the shifter. Back-to-back words are sent with no idle gap between frames. The block sits between the SoC bus-side write logic and the `tx_out` pin.

## Interface

Parameters:
- `DATA_BITS`, 8: data bits per frame, legal 5..8
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity (ignored when `PARITY_EN`=0)
- `STOP_BITS`, 1: stop bits per frame, legal 1 or 2

Ports:
- `Clock`  in  1  system clock; all logic on rising edge
- `Reset`  in  1  asynchronous, active-high reset
- `Enable`  in  1  block enable; when low, ticks are ignored and no words are accepted
- `baud_tick`  in  1  one-`Clock` pulse per bit period, from the baud rate generator
- `tx_data`  in  8  word to send; only bits [DATA_BITS-1:0] are used
- `tx_valid`  in  1  `tx_data` is valid
- `tx_ready`  out  1  holding register empty and `Enable` high
- `tx_out`  out  1  serial line output; idles high
- `busy`  out  1  frame in progress or holding register full
- `frame_done`  out  1  one-cycle pulse at the end of each frame's last stop bit

## Operation

- **Handshake:** a word is accepted on a `Clock` edge where `tx_valid && tx_ready`. It is latched into the holding register and `hold_full` is set. `tx_ready = Enable && !hold_full` (combinational).
- **States:** IDLE, START, DATA, PARITY, STOP. State advances only on edges where `baud_tick && Enable`. All other edges hold state, bit counter and `tx_out`.
- **Load point:** a load occurs on a qualified tick when state is IDLE, or state is STOP on its last stop bit, and `hold_full`=1. On a load:
  - shifter ← hold, `hold_full` ← 0
  - state → START, `tx_out` ← 0
  - at the last stop bit, `frame_done` pulses on that same edge
- **Transitions on a qualified tick:**
  - START → DATA: `tx_out` ← d[0], bit counter ← 0.
  - DATA, counter < DATA_BITS-1: counter+1, `tx_out` ← d[counter+1].
  - DATA, counter = DATA_BITS-1: go to PARITY if `PARITY_EN`, else STOP. `tx_out` ← parity or 1 respectively.
  - PARITY → STOP: `tx_out` ← 1, stop counter ← 0.
  - STOP, not last stop bit: stop counter+1, `tx_out` stays 1.
  - STOP, last stop bit, `hold_full`=0: go to IDLE, `tx_out` stays 1, `frame_done` pulses.
- **Parity:** XOR of d[DATA_BITS-1:0], inverted when `PARITY_ODD`=1.
- **Accept and tick on the same edge:** the new word reaches the hold register only. It is not visible to the load decision until the next qualified tick.
- **`Enable` low mid-frame:** the current bit is stretched. The frame resumes on the first tick after `Enable` returns high.
- **Reset (including mid-frame):** frame is aborted; `tx_out` goes to 1 immediately.
- **`busy`:** `(state != IDLE) || hold_full`.

## Timing

- **Reset values:**
  - state IDLE, `hold_full`=0
  - `tx_out`=1, `busy`=0, `frame_done`=0
  - `tx_ready`=`Enable`
- **Registered outputs:** `tx_out` and `frame_done` update on the edge that samples the qualified tick and are visible the following cycle.
- **First-frame latency:** the start bit begins on the edge of the first qualified tick strictly after the accept edge. The maximum latency is one bit period plus one cycle.
- **Bit duration:** every bit lasts exactly one tick interval while `Enable` stays high.
- **Frame length:** 1 + DATA_BITS + PARITY_EN + STOP_BITS tick intervals.
- **Back-to-back:** if the next word is accepted before the tick that ends the last stop bit, the next start bit begins on that same tick, with zero idle bits between frames.
- **Ready timing:** `tx_ready` rises the cycle after a load and falls the cycle after an accept.

## Test plan

- **Reset:** assert `Reset` with `Enable`=1 → `tx_out`=1, `busy`=0, `frame_done`=0, `tx_ready`=1. Ticks with no `tx_valid` → `tx_out` stays 1.
- **Single 8N1 frame:** send 0xA5 with `baud_tick` every 4 clocks → `tx_out` per bit period is 0,1,0,1,0,0,1,0,1,1. `frame_done` pulses once; `busy` falls after the stop bit.
- **Parity:** with `PARITY_EN`=1, `PARITY_ODD`=0, send 0x07 → parity bit 1. With `PARITY_ODD`=1 → parity bit 0. With `STOP_BITS`=2 → two high bit periods before IDLE.
- **Back-to-back:** send 0x55, then 0xAA accepted during the 0x55 data bits → 20 consecutive bit periods with no idle gap. `tx_ready` stays low from the second accept until the second word loads.
- **Enable stretch and same-edge accept:**
  - Drop `Enable` for 3 ticks during data bit 2 → bit 2 lasts 4 tick intervals; later bits are unaffected.
  - Accept coinciding with a tick in IDLE → start bit begins on the next tick.
- **Reset mid-frame:** assert `Reset` during data bit 4 with hold full → `tx_out`=1 immediately, hold cleared, no `frame_done`. The next word sends a clean full frame.

Source files
------------

// File: rtl/uart_tx_engine.sv
// UART transmitter: one-entry holding register in front of a frame
// sequencer that emits start, DATA_BITS data (LSB first), optional parity
// and STOP_BITS stop bits, advancing one bit per qualified baud tick.
`timescale 1ns/1ps
module uart_tx_engine #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Enable,
    input  logic       baud_tick,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);
    localparam logic       HAS_PAR   = (PARITY_EN != 0);
    localparam logic       ODD_PAR   = (PARITY_ODD != 0);

    state_t     state, state_nxt;
    logic [7:0] hold, shifter;
    logic       hold_full;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic       stop_cnt, stop_cnt_nxt;
    logic       tx_nxt, done_nxt, load;
    logic       qtick, accept, last_bit, last_stop, parity;

    assign qtick     = baud_tick && Enable;
    assign tx_ready  = Enable && !hold_full;
    assign accept    = tx_valid && tx_ready;
    assign busy      = (state != S_IDLE) || hold_full;
    assign last_bit  = (bit_cnt == LAST_BIT);
    assign last_stop = (stop_cnt == LAST_STOP);
    assign parity    = (^(shifter & DATA_MASK)) ^ ODD_PAR;

    // State register plus the frame datapath that moves with it
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            shifter    <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            tx_out     <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            stop_cnt   <= stop_cnt_nxt;
            tx_out     <= tx_nxt;
            frame_done <= done_nxt;
            if (load) shifter <= hold;
        end
    end

    // Holding register: a load empties it, an accept fills it; the two never
    // coincide because accept needs it empty and load needs it full
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (load) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold      <= tx_data;
            hold_full <= 1'b1;
        end
    end

    // Next-state decode; only qualified ticks move the sequencer
    always_comb begin
        state_nxt = state;
        if (qtick) begin
            case (state)
                S_IDLE:   if (hold_full) state_nxt = S_START;
                S_START:  state_nxt = S_DATA;
                S_DATA:   if (last_bit) state_nxt = HAS_PAR ? S_PARITY : S_STOP;
                S_PARITY: state_nxt = S_STOP;
                S_STOP:   if (last_stop) state_nxt = hold_full ? S_START : S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // Line value, counters, load strobe and end-of-frame pulse for this tick
    always_comb begin
        tx_nxt       = tx_out;
        done_nxt     = 1'b0;
        bit_cnt_nxt  = bit_cnt;
        stop_cnt_nxt = stop_cnt;
        load         = 1'b0;
        if (qtick) begin
            case (state)
                S_IDLE: begin
                    if (hold_full) begin
                        load   = 1'b1;
                        tx_nxt = 1'b0;
                    end
                end
                S_START: begin
                    tx_nxt      = shifter[0];
                    bit_cnt_nxt = '0;
                end
                S_DATA: begin
                    if (last_bit) begin
                        // stop counter restarts on every entry to STOP
                        stop_cnt_nxt = 1'b0;
                        tx_nxt       = HAS_PAR ? parity : 1'b1;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        tx_nxt      = shifter[bit_cnt + 3'd1];
                    end
                end
                S_PARITY: begin
                    tx_nxt       = 1'b1;
                    stop_cnt_nxt = 1'b0;
                end
                S_STOP: begin
                    if (!last_stop) begin
                        stop_cnt_nxt = stop_cnt + 1'b1;
                        tx_nxt       = 1'b1;
                    end else begin
                        // frame ends here; a waiting word starts immediately
                        done_nxt = 1'b1;
                        if (hold_full) begin
                            load   = 1'b1;
                            tx_nxt = 1'b0;
                        end else begin
                            tx_nxt = 1'b1;
                        end
                    end
                end
                default: tx_nxt = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: three configurations (8N1, 8E2, 7O1) share clock,
// reset, enable and tick. A line receiver decodes each tx_out stream at the
// qualified ticks and compares every frame with one built from the sent word.
`timescale 1ns/1ps
module tb_uart_tx_engine;
    localparam int TDIV = 4;
    localparam int ND   = 3;

    logic       Clock = 1'b0, Reset = 1'b1, Enable = 1'b1, baud_tick = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [2:0] valid_v = 3'b000;
    logic r0, r1, r2, o0, o1, o2, b0, b1, b2, f0, f1, f2;
    logic [2:0] ready_v, out_v, busy_v, done_v;
    assign ready_v = {r2, r1, r0};
    assign out_v   = {o2, o1, o0};
    assign busy_v  = {b2, b1, b0};
    assign done_v  = {f2, f1, f0};

    int dcfg[ND] = '{8, 8, 7};
    int pcfg[ND] = '{0, 1, 1};
    int ocfg[ND] = '{0, 0, 1};
    int scfg[ND] = '{1, 2, 1};

    int checks = 0, failures = 0;

    // receiver / scoreboard state
    logic [7:0]  sb[ND][$];
    bit          in_frame[ND], pend[ND];
    logic        cur[ND], last_par[ND];
    logic [15:0] bits[ND], last_bits[ND];
    int          nb[ND], idle_cnt[ND], gap[ND], nstart[ND], ndone[ND], start_cyc[ND];
    int          stretch_idx[ND] = '{-1, -1, -1};
    int          dur[ND][16];
    int          cyc = 0, since = 0;

    uart_tx_engine #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .baud_tick(baud_tick),
        .tx_data(tx_data), .tx_valid(valid_v[0]), .tx_ready(r0), .tx_out(o0),
        .busy(b0), .frame_done(f0));
    uart_tx_engine #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_8e2 (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .baud_tick(baud_tick),
        .tx_data(tx_data), .tx_valid(valid_v[1]), .tx_ready(r1), .tx_out(o1),
        .busy(b1), .frame_done(f1));
    uart_tx_engine #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_7o1 (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .baud_tick(baud_tick),
        .tx_data(tx_data), .tx_valid(valid_v[2]), .tx_ready(r2), .tx_out(o2),
        .busy(b2), .frame_done(f2));

    initial forever #5 Clock = ~Clock;

    // one-cycle tick every TDIV clocks, changed on the falling edge
    initial begin
        int c = 0;
        forever begin
            @(negedge Clock);
            c = (c + 1) % TDIV;
            baud_tick = (c == 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic int flen(input int i);
        return 1 + dcfg[i] + pcfg[i] + scfg[i];
    endfunction

    // expected line sequence for one word, bit k of the result = k-th bit period
    function automatic logic [15:0] model_frame(input int i, input logic [7:0] w);
        logic [15:0] f = '0;
        int k, ones = 0;
        for (int j = 0; j < dcfg[i]; j++) begin
            f[1 + j] = w[j];
            ones += int'(w[j]);
        end
        k = 1 + dcfg[i];
        if (pcfg[i] != 0) begin
            if (ocfg[i] == 0) f[k] = ((ones % 2) == 1);
            else              f[k] = ((ones % 2) == 0);
            k++;
        end
        for (int s = 0; s < scfg[i]; s++) f[k + s] = 1'b1;
        return f;
    endfunction

    task automatic finish_frame(input int i);
        logic [7:0] w;
        in_frame[i]  = 1'b0;
        pend[i]      = 1'b1;
        last_bits[i] = bits[i];
        last_par[i]  = bits[i][1 + dcfg[i]];
        if (sb[i].size() == 0) begin
            chk("unexpected_frame", 32'(1), 32'(0));
        end else begin
            w = sb[i].pop_front();
            chk("frame_bits", 32'(bits[i]), 32'(model_frame(i, w)));
        end
        for (int k = 0; k < flen(i) - 1; k++)
            chk("bit_duration", 32'(dur[i][k]), 32'((k == stretch_idx[i]) ? 4 * TDIV : TDIV));
    endtask

    // line receiver: samples 1ns after each rising edge
    initial begin
        bit q;
        forever begin
            @(posedge Clock);
            q = baud_tick && Enable && !Reset;
            cyc++;
            since++;
            #1;
            for (int i = 0; i < ND; i++) begin
                if (Reset) begin
                    in_frame[i] = 1'b0; pend[i] = 1'b0; nb[i] = 0;
                    cur[i] = 1'b1; idle_cnt[i] = 0;
                    sb[i].delete();
                end else if (q) begin
                    chk("frame_done_at_tick", 32'(done_v[i]), 32'(pend[i]));
                    if (pend[i]) ndone[i]++;
                    pend[i] = 1'b0;
                    cur[i]  = out_v[i];
                    if (in_frame[i]) begin
                        dur[i][nb[i] - 1] = since;
                        bits[i][nb[i]]    = out_v[i];
                        nb[i]++;
                        if (nb[i] == flen(i)) finish_frame(i);
                    end else if (!out_v[i]) begin
                        in_frame[i] = 1'b1; nb[i] = 1; bits[i] = '0;
                        gap[i] = idle_cnt[i]; idle_cnt[i] = 0;
                        nstart[i]++; start_cyc[i] = cyc;
                    end else begin
                        idle_cnt[i]++;
                    end
                end else begin
                    chk("line_stable", 32'(out_v[i]), 32'(cur[i]));
                    chk("frame_done_off_tick", 32'(done_v[i]), 32'(0));
                end
            end
            if (q) since = 0;
        end
    end

    task automatic send(input int i, input logic [7:0] w, input bit align, output int acc);
        int budget = 0;
        acc = -1;
        @(negedge Clock); #1;
        if (align)
            while (!baud_tick && budget < 50) begin @(negedge Clock); #1; budget++; end
        tx_data = w;
        valid_v[i] = 1'b1;
        while (!ready_v[i] && budget < 400) begin @(negedge Clock); #1; budget++; end
        if (!ready_v[i]) begin
            chk("send_timeout", 32'(0), 32'(1));
            valid_v[i] = 1'b0;
        end else begin
            @(posedge Clock);
            sb[i].push_back(w);
            #1 valid_v[i] = 1'b0;
            #1 acc = cyc;
        end
    endtask

    task automatic wait_idle(input int i);
        int budget = 0;
        while ((sb[i].size() != 0 || in_frame[i] || pend[i]) && budget < 3000) begin
            @(negedge Clock); #1; budget++;
        end
        chk("idle_reached", 32'(budget < 3000), 32'(1));
        chk("busy_after_frame", 32'(busy_v[i]), 32'(0));
        chk("line_idle_high", 32'(out_v[i]), 32'(1));
    endtask

    task automatic wait_bit(input int i, input int n);
        int budget = 0;
        while (!(in_frame[i] && nb[i] >= n) && budget < 300) begin
            @(negedge Clock); #1; budget++;
        end
        chk("bit_reached", 32'(budget < 300), 32'(1));
    endtask

    initial begin
        int acc, s0, d0, budget, c;
        bit rdy_seen;
        logic [7:0] w;

        // reset state
        repeat (3) @(negedge Clock);
        #1;
        for (int i = 0; i < ND; i++) begin
            chk("rst_tx_out", 32'(out_v[i]), 32'(1));
            chk("rst_busy", 32'(busy_v[i]), 32'(0));
            chk("rst_frame_done", 32'(done_v[i]), 32'(0));
            chk("rst_ready", 32'(ready_v[i]), 32'(1));
        end
        Enable = 1'b0; #1;
        chk("ready_follows_enable", 32'(ready_v), 32'(0));
        Enable = 1'b1;
        @(negedge Clock); #1 Reset = 1'b0;
        repeat (3 * TDIV) @(negedge Clock);
        #1 chk("idle_ticks_line_high", 32'(out_v), 32'(3'b111));

        // single 8N1 frame of 0xA5: 0,1,0,1,0,0,1,0,1,1
        d0 = ndone[0];
        send(0, 8'hA5, 1'b0, acc);
        chk("busy_after_accept", 32'(busy_v[0]), 32'(1));
        chk("ready_low_after_accept", 32'(ready_v[0]), 32'(0));
        wait_idle(0);
        chk("a5_line_sequence", 32'(last_bits[0]), 32'(16'h034A));
        chk("a5_one_frame_done", 32'(ndone[0] - d0), 32'(1));
        chk("ready_when_idle", 32'(ready_v[0]), 32'(1));

        // parity: 0x07 even -> 1 (with two stop bits), odd over 7 bits -> 0
        send(1, 8'h07, 1'b0, acc);
        wait_idle(1);
        chk("even_parity_bit", 32'(last_par[1]), 32'(1));
        chk("8e2_line_sequence", 32'(last_bits[1]), 32'(16'h0E0E));
        send(2, 8'h07, 1'b0, acc);
        wait_idle(2);
        chk("odd_parity_bit", 32'(last_par[2]), 32'(0));
        chk("7o1_line_sequence", 32'(last_bits[2]), 32'(16'h020E));

        // back-to-back: 0xAA accepted during the data bits of 0x55
        s0 = nstart[0];
        send(0, 8'h55, 1'b0, acc);
        wait_bit(0, 3);
        send(0, 8'hAA, 1'b0, acc);
        rdy_seen = 1'b0;
        budget = 0;
        while (nstart[0] < s0 + 2 && budget < 300) begin
            @(negedge Clock); #1; budget++;
            if (nstart[0] < s0 + 2 && ready_v[0]) rdy_seen = 1'b1;
        end
        chk("ready_low_until_load", 32'(rdy_seen), 32'(0));
        chk("b2b_no_idle_gap", 32'(gap[0]), 32'(0));
        chk("ready_after_load", 32'(ready_v[0]), 32'(1));
        wait_idle(0);

        // Enable low for three ticks during data bit 2 (bit period index 3)
        stretch_idx[0] = 3;
        send(0, 8'($urandom), 1'b0, acc);
        wait_bit(0, 4);
        Enable = 1'b0;
        c = 0;
        budget = 0;
        while (c < 3 && budget < 100) begin
            @(negedge Clock); #1; budget++;
            if (baud_tick) c++;
        end
        chk("ready_low_when_disabled", 32'(ready_v[0]), 32'(0));
        @(posedge Clock); #1 Enable = 1'b1;
        wait_idle(0);
        stretch_idx[0] = -1;

        // accept on the same edge as an idle tick: start bit one tick later
        s0 = nstart[0];
        send(0, 8'($urandom), 1'b1, acc);
        budget = 0;
        while (nstart[0] == s0 && budget < 100) begin @(negedge Clock); #1; budget++; end
        chk("same_edge_start_latency", 32'(start_cyc[0] - acc), 32'(TDIV));
        wait_idle(0);

        // reset during data bit 4 with the hold register full
        send(0, 8'h3C, 1'b0, acc);
        send(0, 8'hC3, 1'b0, acc);
        wait_bit(0, 6);
        d0 = ndone[0];
        Reset = 1'b1; #1;
        chk("midrst_tx_out", 32'(out_v[0]), 32'(1));
        chk("midrst_busy", 32'(busy_v[0]), 32'(0));
        chk("midrst_ready", 32'(ready_v[0]), 32'(1));
        repeat (2) @(negedge Clock);
        #1 Reset = 1'b0;
        repeat (4 * TDIV) @(negedge Clock);
        #1;
        chk("midrst_no_frame_done", 32'(ndone[0] - d0), 32'(0));
        chk("midrst_hold_cleared", 32'(busy_v[0]), 32'(0));
        chk("midrst_line_high", 32'(out_v[0]), 32'(1));
        send(0, 8'h96, 1'b0, acc);
        wait_idle(0);
        chk("postrst_clean_frame", 32'(ndone[0] - d0), 32'(1));

        // random words with random spacing on every configuration
        for (int i = 0; i < ND; i++) begin
            d0 = ndone[i];
            for (int n = 0; n < 8; n++) begin
                w = 8'($urandom);
                send(i, w, 1'b0, acc);
                repeat ($urandom_range(0, 3 * TDIV * 4)) @(negedge Clock);
            end
            wait_idle(i);
            chk("random_frame_count", 32'(ndone[i] - d0), 32'(8));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
